// File: rtl/arb_8_rr.sv
// arb_8_rr: 8-requester arbiter with a bounded grant hold time.
// Optional feature macro: ARB_RR_EN selects round-robin arbitration;
// when it is undefined, arbitration is fixed priority (req[0] highest).
// A grant lasts until the holder pulses rel, withdraws its request, or
// holds the grant for TIMEOUT cycles. At least one idle cycle always
// separates two grants.

module arb_8_rr #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       rel,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       busy,
    output logic       timeout
);

    localparam int unsigned N     = 8;
    localparam int unsigned IDW   = 3;
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [N-1:0]       gnt_q, gnt_d;
    logic [IDW-1:0]     gnt_id_q, gnt_id_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               win_found;
    logic [IDW-1:0]     win_id;

    logic               rel_withdraw;
    logic               rel_limit;

`ifdef ARB_RR_EN
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     rr_idx;

    // Round-robin winner: first set request searching upward from ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        rr_idx    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            rr_idx = ptr_q + IDW'(k);
            if (!win_found && req[rr_idx]) begin
                win_found = 1'b1;
                win_id    = rr_idx;
            end
        end
    end
`else
    // Fixed-priority winner: lowest-indexed set request.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!win_found && req[k]) begin
                win_found = 1'b1;
                win_id    = IDW'(k);
            end
        end
    end
`endif

    // Release conditions of the current holder.
    assign rel_withdraw = !req[gnt_id_q];
    assign rel_limit    = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
`ifdef ARB_RR_EN
        ptr_d     = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                gnt_d    = '0;
                gnt_id_d = '0;
                busy_d   = 1'b0;
                cnt_d    = '0;
                if (win_found) begin
                    state_d  = GRANT;
                    gnt_d    = N'(1) << win_id;
                    gnt_id_d = win_id;
                    busy_d   = 1'b1;
`ifdef ARB_RR_EN
                    ptr_d    = win_id + IDW'(1);
`endif
                end
            end
            GRANT: begin
                if (rel || rel_withdraw || rel_limit) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    gnt_id_d  = '0;
                    busy_d    = 1'b0;
                    cnt_d     = '0;
                    // Pulse only when the hold limit alone ended the grant.
                    timeout_d = rel_limit && !rel && !rel_withdraw;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
                busy_d   = 1'b0;
                cnt_d    = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef ARB_RR_EN
    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: doc/arb_8_rr.md
ARB_8_RR -- requirements
Module: arb_8_rr

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum cycles one grant is held; legal range 2..256.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  8  request lines; bit i is requester i, level-sensitive.
REQ-005 rel  input  1  release pulse from the current grant holder; ignored when no grant is active.
REQ-006 gnt  output  8  one-hot grant, registered; all-zero when idle.
REQ-007 gnt_id  output  3  binary index of the granted requester, registered; 0 when idle.
REQ-008 busy  output  1  high while a grant is active (state GRANT).
REQ-009 timeout  output  1  one-cycle pulse when a grant is force-released by the timeout.

Function
REQ-010 The FSM SHALL have two states, IDLE and GRANT.
REQ-011 In IDLE, with req != 0, the block SHALL select a winner and enter GRANT on the next edge; gnt, gnt_id and busy update on that same edge (1-cycle request-to-grant latency).
REQ-012 In IDLE, with req == 0, the block SHALL remain in IDLE with gnt=0, gnt_id=0 and busy=0.
REQ-013 With the round-robin option enabled, the search SHALL start at ptr and wrap modulo 8; the first set req bit wins.
REQ-014 ptr SHALL load (winner+1) mod 8 on each grant; winner 7 wraps ptr to 0.
REQ-015 In GRANT, gnt, gnt_id and ptr SHALL hold, and req bits of other requesters SHALL be ignored.
REQ-016 Hold counter (ceil(log2(TIMEOUT)) bits): cleared to 0 on grant entry; increments each GRANT cycle.
REQ-017 Release conditions: rel=1, or req[gnt_id]=0 (requester withdrew), or counter==TIMEOUT-1 (timeout).
REQ-018 On any release condition, the block SHALL return to IDLE on the next edge with gnt=0 and busy=0.
REQ-019 The minimum gap between consecutive grants SHALL be one IDLE cycle; back-to-back grants without that gap SHALL NOT occur.
REQ-020 timeout SHALL pulse for one cycle, coincident with the IDLE entry edge, only when the counter limit alone caused the release.
REQ-021 If rel or withdrawal coincides with the counter limit, the release SHALL count as normal and timeout SHALL stay 0.
REQ-022 gnt SHALL always be one-hot or zero, and gnt SHALL equal (1 << gnt_id) whenever busy=1.

Reset
REQ-023 While rst_n=0, the block SHALL force state=IDLE, gnt=0, gnt_id=0, busy=0, timeout=0, counter=0 and ptr=0, independent of clk.
REQ-024 Assertion of rst_n mid-grant SHALL drop gnt immediately, and no timeout pulse SHALL follow.
REQ-025 After rst_n deasserts, the first arbitration SHALL occur on the first clk edge with req != 0.

Configuration
REQ-026 The macro ARB_RR_EN SHALL select the arbitration policy.
REQ-027 With ARB_RR_EN defined, arbitration SHALL be round-robin per REQ-013 and REQ-014.
REQ-028 Without ARB_RR_EN, arbitration SHALL be fixed-priority with req[0] highest and req[7] lowest; ptr and its logic SHALL be absent, and all other behaviour is unchanged.

Verification
REQ-029 Scenario (ARB_RR_EN): reset, then req=8'hFF held, rel pulsed 1 cycle after each grant -> gnt_id sequence 0,1,2,3,4,5,6,7,0, with one idle cycle between grants.
REQ-030 Scenario (no ARB_RR_EN): req=8'b1010_0100 -> gnt=8'h04, gnt_id=2; on release, req[2] drops -> next grant gnt_id=5.
REQ-031 Scenario (TIMEOUT=16): req[3] held, no rel -> busy high for 16 cycles, then timeout=1 for one cycle with gnt=0; regrant to 3 after the idle cycle.
REQ-032 Scenario (TIMEOUT=16): rel asserted in the same cycle the counter reaches 15 -> release with timeout=0.
REQ-033 Scenario: during grant to requester 6, rst_n pulsed low -> gnt=0, busy=0 asynchronously; after reset with ARB_RR_EN and req=8'hC0 -> gnt_id=6 (ptr=0).
REQ-034 Scenario: grant to requester 1, req[1] drops with rel=0 -> IDLE next edge; a new request on req[4] that arrived mid-grant is granted after the idle cycle.
